// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one pending execution
// result per cycle and registers it onto the CDB, with flush on misprediction.
module cdb_arbiter #(
   parameter  int N_SRC   = 3,
   parameter  int ROB_LOG = 4,
   localparam int SRC_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       jump_flag,
   input  logic [N_SRC-1:0]           src_valid,
   input  logic [N_SRC*ROB_LOG-1:0]   src_RobId,
   input  logic [N_SRC*32-1:0]        src_value,
   output logic [N_SRC-1:0]           src_ready,
   output logic                       cdb_valid,
   output logic [ROB_LOG-1:0]         cdb_RobId,
   output logic [31:0]                cdb_value,
   output logic [SRC_W-1:0]           cdb_src,
   output logic                       tag_err
);

   logic                 cdb_valid_q, cdb_valid_d;
   logic [ROB_LOG-1:0]   cdb_robid_q, cdb_robid_d;
   logic [31:0]          cdb_value_q, cdb_value_d;
   logic [SRC_W-1:0]     cdb_src_q,   cdb_src_d;
   logic [SRC_W-1:0]     rr_q,        rr_d;
   logic                 tag_err_q,   tag_err_d;

   logic                 arb_en_s;
   logic                 found_s;
   logic                 hit_s;
   logic [SRC_W:0]       sum_s;
   logic [SRC_W-1:0]     idx_s;
   logic [N_SRC-1:0]     grant_s;
   logic [SRC_W-1:0]     gnt_idx_s;
   logic [ROB_LOG-1:0]   gnt_id_s;
   logic [31:0]          gnt_val_s;

   // Rotating priority search starting at rr; reset, stall and flush mask every grant.
   always_comb begin
      arb_en_s  = rst & rdy & ~jump_flag;
      found_s   = 1'b0;
      hit_s     = 1'b0;
      sum_s     = '0;
      idx_s     = '0;
      grant_s   = '0;
      gnt_idx_s = '0;
      for (int k = 0; k < N_SRC; k++) begin
         sum_s     = {1'b0, rr_q} + (SRC_W+1)'(k);
         idx_s     = (sum_s >= (SRC_W+1)'(N_SRC)) ? SRC_W'(sum_s - (SRC_W+1)'(N_SRC))
                                                   : SRC_W'(sum_s);
         hit_s     = arb_en_s & ~found_s & src_valid[idx_s];
         grant_s[idx_s] = grant_s[idx_s] | hit_s;
         gnt_idx_s = hit_s ? idx_s : gnt_idx_s;
         found_s   = found_s | hit_s;
      end
   end

   // One-hot AND-OR payload mux driven by the grant vector.
   always_comb begin
      gnt_id_s  = '0;
      gnt_val_s = '0;
      for (int k = 0; k < N_SRC; k++) begin
         gnt_id_s  = gnt_id_s  | (src_RobId[k*ROB_LOG +: ROB_LOG] & {ROB_LOG{grant_s[k]}});
         gnt_val_s = gnt_val_s | (src_value[k*32 +: 32] & {32{grant_s[k]}});
      end
   end

   // Next-state for the CDB register, round-robin pointer and sticky tag error.
   always_comb begin
      cdb_valid_d = cdb_valid_q;
      cdb_robid_d = cdb_robid_q;
      cdb_value_d = cdb_value_q;
      cdb_src_d   = cdb_src_q;
      rr_d        = rr_q;
      tag_err_d   = tag_err_q;
      if (rdy) begin
         if (jump_flag) begin
            cdb_valid_d = 1'b0;
            rr_d        = '0;
         end else if (found_s) begin
            cdb_valid_d = 1'b1;
            cdb_robid_d = gnt_id_s;
            cdb_value_d = gnt_val_s;
            cdb_src_d   = gnt_idx_s;
            rr_d        = (gnt_idx_s == SRC_W'(N_SRC-1)) ? '0 : gnt_idx_s + SRC_W'(1);
            tag_err_d   = tag_err_q | (gnt_id_s == ROB_LOG'(0));
         end else begin
            cdb_valid_d = 1'b0;
         end
      end else begin
         // rdy low freezes the core, so an undelivered broadcast stays on the bus
         cdb_valid_d = cdb_valid_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_valid_q <= 1'b0;
         cdb_robid_q <= '0;
         cdb_value_q <= 32'h0000_0000;
         cdb_src_q   <= '0;
         rr_q        <= '0;
         tag_err_q   <= 1'b0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_robid_q <= cdb_robid_d;
         cdb_value_q <= cdb_value_d;
         cdb_src_q   <= cdb_src_d;
         rr_q        <= rr_d;
         tag_err_q   <= tag_err_d;
      end
   end

   assign src_ready = grant_s;
   assign cdb_valid = cdb_valid_q;
   assign cdb_RobId = cdb_robid_q;
   assign cdb_value = cdb_value_q;
   assign cdb_src   = cdb_src_q;
   assign tag_err   = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a round-robin model predicts each grant and
// queues the expected broadcast, which is popped when the CDB register updates.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_flag;
   logic [2:0]  src_valid;
   logic [11:0] src_RobId;
   logic [95:0] src_value;
   logic [2:0]  src_ready;
   logic        cdb_valid;
   logic [3:0]  cdb_RobId;
   logic [31:0] cdb_value;
   logic [1:0]  cdb_src;
   logic        tag_err;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] val;
      logic [1:0]  src;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rr_m    = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.N_SRC(3), .ROB_LOG(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
      .src_valid(src_valid), .src_RobId(src_RobId), .src_value(src_value),
      .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_RobId(cdb_RobId),
      .cdb_value(cdb_value), .cdb_src(cdb_src), .tag_err(tag_err)
   );

   function automatic logic [2:0] model_grant(input logic [2:0] v, input int rr, input logic en);
      logic [2:0] g;
      logic       f;
      int         i;
      g = 3'b000;
      f = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i = (rr + k) % 3;
         if (en && !f && v[i[1:0]]) begin
            g[i[1:0]] = 1'b1;
            f = 1'b1;
         end
      end
      return g;
   endfunction

   task automatic set_src(input int i, input logic [3:0] id, input logic [31:0] val);
      src_RobId[i*4 +: 4]   = id;
      src_value[i*32 +: 32] = val;
   endtask

   // Predict this cycle's grant and queue the broadcast it must produce.
   task automatic predict(output logic [2:0] g);
      exp_t e;
      #1;
      g = model_grant(src_valid, rr_m, rst && rdy && !jump_flag);
      for (int k = 0; k < 3; k++) begin
         if (g[k]) begin
            e.id  = src_RobId[k*4 +: 4];
            e.val = src_value[k*32 +: 32];
            e.src = 2'(k);
            sb.push_back(e);
         end
      end
   endtask

   task automatic tick(input logic [2:0] g);
      @(posedge clk);
      #1;
      if (rdy && jump_flag) rr_m = 0;
      else if (rdy) begin
         for (int k = 0; k < 3; k++) if (g[k]) rr_m = (k + 1) % 3;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; rdy = 1'b1; jump_flag = 1'b0; src_valid = 3'b111;
      set_src(0, 4'd1, 32'h0); set_src(1, 4'd2, 32'h0); set_src(2, 4'd3, 32'h0);
      #2;
      n_tests++;
      if (cdb_valid !== 1'b0 || cdb_RobId !== 4'd0 || cdb_value !== 32'h0 ||
          cdb_src !== 2'd0 || tag_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b id=%0d val=%h src=%0d err=%b, want all zero",
                  cdb_valid, cdb_RobId, cdb_value, cdb_src, tag_err);
      end
      n_tests++;
      if (src_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 000", src_ready);
      end
      src_valid = 3'b000;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single;
      logic [2:0] g;
      exp_t e;
      src_valid = 3'b010; set_src(1, 4'd5, 32'h1234);
      predict(g);
      n_tests++;
      if (src_ready !== 3'b010 || g !== 3'b010) begin
         n_fail++;
         $display("FAIL single_ready: got %b want 010", src_ready);
      end
      tick(g);
      src_valid = 3'b000;
      e = sb.pop_front();
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_RobId !== e.id || cdb_value !== e.val || cdb_src !== e.src) begin
         n_fail++;
         $display("FAIL single_cdb: got v=%b id=%0d val=%h src=%0d, want v=1 id=%0d val=%h src=%0d",
                  cdb_valid, cdb_RobId, cdb_value, cdb_src, e.id, e.val, e.src);
      end
      predict(g);
      tick(g);
      n_tests++;
      if (cdb_valid !== 1'b0 || cdb_RobId !== 4'd5 || cdb_src !== 2'd1) begin
         n_fail++;
         $display("FAIL single_idle: got v=%b id=%0d src=%0d, want v=0 id=5 src=1",
                  cdb_valid, cdb_RobId, cdb_src);
      end
   endtask

   task automatic test_contention;
      logic [2:0] g;
      logic [2:0] seq [6];
      exp_t e;
      seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      src_valid = 3'b111; jump_flag = 1'b1;
      set_src(0, 4'd1, 32'hA0); set_src(1, 4'd2, 32'hA1); set_src(2, 4'd3, 32'hA2);
      predict(g);
      tick(g);
      jump_flag = 1'b0;
      for (int c = 0; c < 6; c++) begin
         predict(g);
         n_tests++;
         if (src_ready !== seq[c] || g !== seq[c]) begin
            n_fail++;
            $display("FAIL contention_grant[%0d]: got %b want %b", c, src_ready, seq[c]);
         end
         tick(g);
         if (|g) begin
            e = sb.pop_front();
            n_tests++;
            if (cdb_valid !== 1'b1 || cdb_RobId !== e.id || cdb_value !== e.val || cdb_src !== e.src) begin
               n_fail++;
               $display("FAIL contention_cdb[%0d]: got v=%b id=%0d src=%0d, want v=1 id=%0d src=%0d",
                        c, cdb_valid, cdb_RobId, cdb_src, e.id, e.src);
            end
         end
      end
   endtask

   task automatic test_wrap;
      logic [2:0] g;
      logic [2:0] want;
      exp_t e;
      src_valid = 3'b101; set_src(0, 4'd4, 32'hB0); set_src(2, 4'd6, 32'hB2);
      for (int c = 0; c < 2; c++) begin
         want = (c == 0) ? 3'b001 : 3'b100;
         predict(g);
         n_tests++;
         if (src_ready !== want || g !== want) begin
            n_fail++;
            $display("FAIL wrap_grant[%0d]: got %b want %b", c, src_ready, want);
         end
         tick(g);
         src_valid = src_valid & ~g;
         if (|g) begin
            e = sb.pop_front();
            n_tests++;
            if (cdb_valid !== 1'b1 || cdb_RobId !== e.id || cdb_value !== e.val || cdb_src !== e.src) begin
               n_fail++;
               $display("FAIL wrap_cdb[%0d]: got id=%0d src=%0d, want id=%0d src=%0d",
                        c, cdb_RobId, cdb_src, e.id, e.src);
            end
         end
      end
   endtask

   task automatic test_flush;
      logic [2:0] g;
      exp_t e;
      src_valid = 3'b011; set_src(0, 4'd8, 32'hC0); set_src(1, 4'd9, 32'hC1);
      jump_flag = 1'b1;
      predict(g);
      n_tests++;
      if (src_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL flush_ready: got %b want 000", src_ready);
      end
      tick(g);
      jump_flag = 1'b0;
      n_tests++;
      if (cdb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_cdb: got v=%b want 0", cdb_valid);
      end
      predict(g);
      n_tests++;
      if (src_ready !== 3'b001 || g !== 3'b001) begin
         n_fail++;
         $display("FAIL flush_regrant: got %b want 001", src_ready);
      end
      tick(g);
      src_valid = src_valid & ~g;
      e = sb.pop_front();
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_RobId !== e.id || cdb_value !== e.val || cdb_src !== e.src) begin
         n_fail++;
         $display("FAIL flush_regrant_cdb: got id=%0d src=%0d, want id=%0d src=%0d",
                  cdb_RobId, cdb_src, e.id, e.src);
      end
   endtask

   task automatic test_stall;
      logic [2:0] g;
      exp_t e;
      src_valid = 3'b010; set_src(1, 4'd7, 32'hD1);
      predict(g);
      tick(g);
      e = sb.pop_front();
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_RobId !== e.id || cdb_src !== e.src) begin
         n_fail++;
         $display("FAIL stall_setup: got v=%b id=%0d src=%0d, want v=1 id=%0d src=%0d",
                  cdb_valid, cdb_RobId, cdb_src, e.id, e.src);
      end
      src_valid = 3'b100; set_src(2, 4'd10, 32'hD2); rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         predict(g);
         n_tests++;
         if (src_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_ready[%0d]: got %b want 000", c, src_ready);
         end
         tick(g);
         n_tests++;
         if (cdb_valid !== 1'b1 || cdb_RobId !== 4'd7) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b id=%0d, want v=1 id=7", c, cdb_valid, cdb_RobId);
         end
      end
      rdy = 1'b1;
      predict(g);
      n_tests++;
      if (src_ready !== 3'b100 || g !== 3'b100) begin
         n_fail++;
         $display("FAIL stall_resume: got %b want 100", src_ready);
      end
      tick(g);
      src_valid = 3'b000;
      e = sb.pop_front();
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_RobId !== e.id || cdb_value !== e.val || cdb_src !== e.src) begin
         n_fail++;
         $display("FAIL stall_resume_cdb: got id=%0d src=%0d, want id=%0d src=%0d",
                  cdb_RobId, cdb_src, e.id, e.src);
      end
   endtask

   task automatic test_tag_err;
      logic [2:0] g;
      exp_t e;
      src_valid = 3'b001; set_src(0, 4'd0, 32'hDEAD);
      predict(g);
      tick(g);
      src_valid = 3'b000;
      e = sb.pop_front();
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_RobId !== e.id || cdb_value !== e.val || tag_err !== 1'b1) begin
         n_fail++;
         $display("FAIL tag_err_set: got v=%b id=%0d val=%h err=%b, want v=1 id=%0d val=%h err=1",
                  cdb_valid, cdb_RobId, cdb_value, tag_err, e.id, e.val);
      end
      for (int c = 0; c < 2; c++) begin
         predict(g);
         tick(g);
         n_tests++;
         if (tag_err !== 1'b1 || cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tag_err_sticky[%0d]: got err=%b v=%b, want err=1 v=0", c, tag_err, cdb_valid);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [2:0] g;
      src_valid = 3'b111;
      set_src(0, 4'd1, 32'hE0); set_src(1, 4'd2, 32'hE1); set_src(2, 4'd3, 32'hE2);
      for (int c = 0; c < 2; c++) begin
         predict(g);
         tick(g);
         void'(sb.pop_front());
      end
      #2;
      rst = 1'b0;
      #1;
      n_tests++;
      if (cdb_valid !== 1'b0 || tag_err !== 1'b0 || src_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid: got v=%b err=%b ready=%b, want 0 0 000", cdb_valid, tag_err, src_ready);
      end
      sb.delete();
      rr_m = 0;
      #1;
      rst = 1'b1;
      predict(g);
      n_tests++;
      if (src_ready !== 3'b001 || g !== 3'b001) begin
         n_fail++;
         $display("FAIL reset_mid_first: got %b want 001", src_ready);
      end
      tick(g);
      void'(sb.pop_front());
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_RobId !== 4'd1) begin
         n_fail++;
         $display("FAIL reset_mid_cdb: got v=%b src=%0d id=%0d, want v=1 src=0 id=1",
                  cdb_valid, cdb_src, cdb_RobId);
      end
   endtask

   initial begin
      src_RobId = '0;
      src_value = '0;
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_flush();
      test_stall();
      test_tag_err();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, want finish before 100000");
      $fatal(1);
   end

endmodule
